char_frame_reader: RTL
======================

CHAR_FRAME_READER -- requirements
Module: char_frame_reader

Interface
REQ-001 Parameter DEPTH, default 160, maximum characters per message frame.
REQ-002 Parameter CHAR_W, default 32, bits per character.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  8  buffer write index.
- wr_data  in  CHAR_W  character to store.
- len_in  in  8  frame length in characters; sampled on accepted start.
- tag_in  in  1  ham/spam tag; sampled on accepted start.
- start  in  1  request to stream the buffered frame.
- busy  out  1  frame streaming in progress.
- tok_valid  out  CHAR_W-path valid, 1 bit, character available to tokenizer.
- tok_data  out  CHAR_W  current character.
- tok_last  out  1  current character is the final one of the frame.
- tok_ready  in  1  tokenizer accepts character.
- tag_out  out  1  tag latched for the current frame.
- done  out  1  one-cycle pulse after the last character is accepted.
- err_len  out  1  one-cycle pulse on a rejected start.

Function
REQ-004 Buffer: DEPTH x CHAR_W register array; write when wr_en=1, busy=0 and wr_addr<DEPTH; all other writes are ignored.
REQ-005 FSM states: IDLE, STREAM, DONE.
REQ-006 IDLE: start=1 with 1<=len_in<=DEPTH is accepted; latch len_in and tag_in, set idx=0, go to STREAM.
REQ-007 IDLE: start=1 with len_in=0 or len_in>DEPTH pulses err_len in the next cycle and stays in IDLE.
REQ-008 Latency: the cycle after an accepted start, tok_valid=1, tok_data=buf[0], busy=1.
REQ-009 In STREAM, tok_valid stays 1 and tok_data/tok_last are held stable until tok_valid&tok_ready.
REQ-010 A handshake with idx<len-1 presents buf[idx+1] the next cycle, giving one character per cycle while tok_ready=1.
REQ-011 tok_last=1 exactly when idx=len-1; len=1 gives tok_last on the first character.
REQ-012 A handshake with tok_last=1 moves to DONE: tok_valid=0, done=1 for one cycle, then IDLE with busy=0.
REQ-013 start is ignored in STREAM and DONE; a write to the buffer in DONE is ignored.
REQ-014 tag_out holds the latched tag from acceptance until the next accepted start.
REQ-015 tok_data is 0 whenever tok_valid=0.

Reset
REQ-016 reset=0 asynchronously forces IDLE, idx=0, and busy, tok_valid, tok_data, tok_last, tag_out, done, err_len all to 0.
REQ-017 Reset mid-stream abandons the frame without asserting done; buffer contents are not cleared.

Configuration
REQ-018 Macro CHAR_FRAME_LOWERCASE_EN defined: tok_data with upper CHAR_W-8 bits zero and low byte 0x41-0x5A is presented with bit 5 set (ASCII lowercase); all other values pass unchanged.
REQ-019 Macro undefined: tok_data equals the stored buffer word exactly.

Verification
REQ-020 Write "Hi!" (0x48,0x69,0x21) at 0..2, len_in=3, tag_in=1, start, tok_ready=1 -> 0x48,0x69,0x21 on three consecutive cycles, tok_last on 0x21, done next cycle, tag_out=1.
REQ-021 Same frame with tok_ready toggling 1,0,0,1,1 -> no character lost or duplicated; tok_data stable while stalled.
REQ-022 start with len_in=0, then with len_in=161 -> err_len pulses twice, busy stays 0, tok_valid stays 0.
REQ-023 len_in=160, full buffer, tok_ready=1 -> 160 characters in 160 cycles, tok_last only on index 159.
REQ-024 reset=0 at the 2nd character -> outputs 0 immediately, no done; restart with len_in=3 streams the original buffer.
REQ-025 With CHAR_FRAME_LOWERCASE_EN: stored 0x48 -> 0x68, and 0x0000_0148 -> unchanged; without the macro, 0x48 -> 0x48.

Source files
------------

// File: rtl/char_frame_reader.sv
// Buffers one message frame of characters and streams it to a tokenizer under valid/ready.
// Optional CHAR_FRAME_LOWERCASE_EN folds ASCII 'A'-'Z' in byte-wide words to lowercase on output.
module char_frame_reader #(
    parameter int DEPTH  = 160,
    parameter int CHAR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [7:0]        wr_addr,
    input  logic [CHAR_W-1:0] wr_data,
    input  logic [7:0]        len_in,
    input  logic              tag_in,
    input  logic              start,
    output logic              busy,
    output logic              tok_valid,
    output logic [CHAR_W-1:0] tok_data,
    output logic              tok_last,
    input  logic              tok_ready,
    output logic              tag_out,
    output logic              done,
    output logic              err_len
);

    typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

    state_t            state, state_nxt;
    logic [CHAR_W-1:0] mem [DEPTH];
    logic [7:0]        idx;
    logic [7:0]        len_r;
    logic              tag_r;
    logic              err_r;
    logic              len_ok;
    logic              accept;
    logic              reject;
    logic              hs;

    function automatic logic [CHAR_W-1:0] xform(input logic [CHAR_W-1:0] d);
        logic [CHAR_W-1:0] r;
        r = d;
`ifdef CHAR_FRAME_LOWERCASE_EN
        if (((d >> 8) == '0) && (d[7:0] >= 8'h41) && (d[7:0] <= 8'h5A))
            r[5] = 1'b1;
`endif
        return r;
    endfunction

    assign len_ok = (len_in != 8'd0) && (32'(len_in) <= DEPTH);
    assign accept = (state == IDLE) && start && len_ok;
    assign reject = (state == IDLE) && start && !len_ok;

    // Writes are locked out for the whole busy window so the frame cannot change under the reader.
    always_ff @(posedge clk) begin
        if (wr_en && !busy && (32'(wr_addr) < DEPTH))
            mem[wr_addr] <= wr_data;
    end

    assign busy      = (state != IDLE);
    assign tok_valid = (state == STREAM);
    assign tok_last  = tok_valid && (idx == len_r - 8'd1);
    assign tok_data  = tok_valid ? xform(mem[idx]) : '0;
    assign hs        = tok_valid && tok_ready;
    assign done      = (state == DONE);
    assign tag_out   = tag_r;
    assign err_len   = err_r;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = STREAM;
            STREAM:  if (hs && tok_last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            len_r <= '0;
            tag_r <= 1'b0;
            err_r <= 1'b0;
        end else begin
            state <= state_nxt;
            err_r <= reject;
            if (accept) begin
                idx   <= '0;
                len_r <= len_in;
                tag_r <= tag_in;
            end else if (hs && !tok_last) begin
                idx <= idx + 8'd1;
            end
        end
    end

endmodule
